// File: rtl/addr_sn_pkg.sv
// Shared types and residue helpers for the digit-serial adder with mod-3 checking.
package addr_sn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Weight of bit i modulo 3: 2^i mod 3 is 1 for even i and 2 for odd i.
  // The sign bit of a two's-complement value carries a negative weight,
  // so its residue is negated (1 <-> 2).
  function automatic logic [1:0] res_w(input int unsigned i, input logic msb);
    logic [1:0] w;
    w = i[0] ? 2'd2 : 2'd1;
    if (msb) begin
      w = (w == 2'd1) ? 2'd2 : 2'd1;
    end
    return w;
  endfunction

  // Addition of two residues in {0,1,2}, result kept in {0,1,2}.
  function automatic logic [1:0] mod3_add(input logic [1:0] x, input logic [1:0] y);
    logic [2:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= 3'd3) begin
      s = s - 3'd3;
    end
    return s[1:0];
  endfunction

endpackage

// File: rtl/addr_digit_add.sv
// DIGIT-bit ripple-carry slice: the only arithmetic the serial adder reuses each cycle.
module addr_digit_add #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout
);

  logic [DIGIT:0] c;

  assign c[0] = cin;

  generate
    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_bit
      assign s[gi]    = a[gi] ^ b[gi] ^ c[gi];
      assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign cout = c[DIGIT];

endmodule

// File: rtl/addr_sn_serial_rc.sv
// Digit-serial signed adder: LSB-first, DIGIT bits per cycle, with a mod-3
// residue check on every result and a saturating count of faulty results.
module addr_sn_serial_rc
  import addr_sn_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             inj_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             fault,
  output logic [CNT_W-1:0] fault_count
);

  localparam int N     = WIDTH / DIGIT;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t            state_reg, state_next;
  logic [WIDTH-1:0]  a_sh_reg, b_sh_reg;
  logic [WIDTH-1:0]  sum_sh_reg;
  logic              carry_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [1:0]        ra_reg, rb_reg, rs_reg;
  logic [WIDTH:0]    sum_reg;
  logic              fault_reg;
  logic [CNT_W-1:0]  fault_count_reg;

  logic [DIGIT-1:0]       dsum;
  logic                   dcout;
  logic                   c_w;
  logic                   is_last;
  logic [WIDTH+DIGIT-1:0] sum_cat;
  logic [WIDTH-1:0]       sum_sh_next;
  logic                   sum_msb;
  logic [1:0]             ra_next, rb_next, rs_next, rs_final;
  logic                   fault_next;

  addr_digit_add #(.DIGIT(DIGIT)) u_digit (
    .a    (a_sh_reg[DIGIT-1:0]),
    .b    (b_sh_reg[DIGIT-1:0]),
    .cin  (carry_reg),
    .s    (dsum),
    .cout (dcout)
  );

  // The test hook inverts the carry leaving this digit; on the last digit that
  // carry is c_W, which only feeds the sign bit of the extended sum.
  assign c_w     = dcout ^ inj_carry;
  assign is_last = (idx_reg == LAST_IDX);
  assign sum_cat = {dsum, sum_sh_reg};
  assign sum_sh_next = sum_cat[WIDTH+DIGIT-1:DIGIT];
  assign sum_msb = a_sh_reg[DIGIT-1] ^ b_sh_reg[DIGIT-1] ^ c_w;

  // Fold this digit of a, b and the produced sum bits into the running residues.
  always_comb begin
    ra_next = ra_reg;
    rb_next = rb_reg;
    rs_next = rs_reg;
    for (int j = 0; j < DIGIT; j++) begin
      if (a_sh_reg[j]) begin
        ra_next = mod3_add(ra_next, res_w(int'(idx_reg) * DIGIT + j,
                                          (int'(idx_reg) * DIGIT + j) == WIDTH - 1));
      end
      if (b_sh_reg[j]) begin
        rb_next = mod3_add(rb_next, res_w(int'(idx_reg) * DIGIT + j,
                                          (int'(idx_reg) * DIGIT + j) == WIDTH - 1));
      end
      // Sum bits below WIDTH are all non-sign bits of the WIDTH+1-bit result.
      if (dsum[j]) begin
        rs_next = mod3_add(rs_next, res_w(int'(idx_reg) * DIGIT + j, 1'b0));
      end
    end
    rs_final   = sum_msb ? mod3_add(rs_next, res_w(WIDTH, 1'b1)) : rs_next;
    fault_next = (mod3_add(ra_next, rb_next) != rs_final);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: accept in IDLE, N digit cycles in RUN, hold in DONE until taken.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = RUN;
      RUN:     if (is_last) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: handshakes follow the registered state; result registers are zero outside DONE.
  always_comb begin
    in_ready    = (state_reg == IDLE);
    out_valid   = (state_reg == DONE);
    sum         = sum_reg;
    fault       = fault_reg;
    fault_count = fault_count_reg;
  end

  // Datapath: latch operands on accept, shift one digit per RUN cycle, register result on the last digit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh_reg        <= '0;
      b_sh_reg        <= '0;
      sum_sh_reg      <= '0;
      carry_reg       <= 1'b0;
      idx_reg         <= '0;
      ra_reg          <= 2'd0;
      rb_reg          <= 2'd0;
      rs_reg          <= 2'd0;
      sum_reg         <= '0;
      fault_reg       <= 1'b0;
      fault_count_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_sh_reg   <= a;
            b_sh_reg   <= b;
            sum_sh_reg <= '0;
            carry_reg  <= 1'b0;
            idx_reg    <= '0;
            ra_reg     <= 2'd0;
            rb_reg     <= 2'd0;
            rs_reg     <= 2'd0;
          end
        end
        RUN: begin
          a_sh_reg   <= a_sh_reg >> DIGIT;
          b_sh_reg   <= b_sh_reg >> DIGIT;
          sum_sh_reg <= sum_sh_next;
          carry_reg  <= c_w;
          idx_reg    <= is_last ? '0 : idx_reg + 1'b1;
          ra_reg     <= ra_next;
          rb_reg     <= rb_next;
          rs_reg     <= rs_next;
          if (is_last) begin
            sum_reg   <= {sum_msb, sum_sh_next};
            fault_reg <= fault_next;
            if (fault_next && (fault_count_reg != '1)) begin
              fault_count_reg <= fault_count_reg + 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            sum_reg   <= '0;
            fault_reg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_addr_sn_serial_rc.sv
// Self-checking bench for addr_sn_serial_rc (WIDTH=8, DIGIT=2): directed corner
// cases followed by randomized operands with occasional injected carry faults.
module tb_addr_sn_serial_rc;

  localparam int WIDTH = 8;
  localparam int DIGIT = 2;
  localparam int CNT_W = 8;
  localparam int N     = WIDTH / DIGIT;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b;
  logic             inj_carry;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   sum;
  logic             fault;
  logic [CNT_W-1:0] fault_count;

  int tests_run    = 0;
  int tests_failed = 0;
  int exp_fc       = 0;
  int n_inj        = 0;

  addr_sn_serial_rc #(.WIDTH(WIDTH), .DIGIT(DIGIT), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .inj_carry   (inj_carry),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sum         (sum),
    .fault       (fault),
    .fault_count (fault_count)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: exact signed sum; a flipped carry out of digit k moves the
  // result by +-2^(DIGIT*(k+1)) depending on the true carry at that position.
  function automatic logic [WIDTH:0] model_sum(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input int flip);
    int s, m, c;
    s = int'($signed(x)) + int'($signed(y));
    if (flip >= 0) begin
      m = DIGIT * (flip + 1);
      c = ((int'(x) % (1 << m)) + (int'(y) % (1 << m))) >> m;
      s = (c != 0) ? s - (1 << m) : s + (1 << m);
    end
    return s[WIDTH:0];
  endfunction

  // One full transaction: offer, optional carry flip on digit 'flip',
  // 'stall' cycles of backpressure, then handshake.
  task automatic do_op(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                       input int flip, input int stall, input bit hold);
    int waitc, lat;
    logic [WIDTH:0] es;
    waitc = 0;
    while (!in_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (!in_ready) begin
      chk("in_ready_wait", 32'(in_ready), 32'd1);
      return;
    end
    a = xa;
    b = xb;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = hold;
    if (hold) begin
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
    end
    lat = 0;
    while (!out_valid && lat < 20) begin
      inj_carry = (lat == flip);
      @(negedge clk);
      lat++;
    end
    inj_carry = 1'b0;
    chk("latency", 32'(lat), 32'(N));
    es = model_sum(xa, xb, flip);
    if (flip >= 0) begin
      exp_fc = (exp_fc == 255) ? 255 : exp_fc + 1;
    end
    chk("sum", 32'(sum), 32'(es));
    chk("fault", 32'(fault), 32'(flip >= 0));
    chk("fault_count", 32'(fault_count), 32'(exp_fc));
    for (int k = 0; k < stall; k++) begin
      out_ready = 1'b0;
      @(negedge clk);
      chk("hold", {20'd0, out_valid, in_ready, fault, sum}, {20'd0, 1'b1, 1'b0, flip >= 0, es});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("release", {20'd0, out_valid, in_ready, fault, sum}, {20'd0, 1'b0, 1'b1, 1'b0, 9'd0});
    $display("[TB] op a=%02h b=%02h flip=%0d sum=%03h fault=%0d cnt=%0d",
             xa, xb, flip, sum, fault, fault_count);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int flip, stall;
    bit seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    inj_carry = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("reset", {20'd0, in_ready, out_valid, fault, sum}, {20'd0, 1'b1, 1'b0, 1'b0, 9'd0});
    chk("reset_cnt", 32'(fault_count), 32'd0);

    // Directed corners.
    do_op(8'h7F, 8'h01, -1, 0, 1'b0);
    do_op(8'h80, 8'h80, -1, 0, 1'b0);
    do_op(8'hFF, 8'h01, -1, 0, 1'b0);
    do_op(8'h00, 8'h00, 0, 0, 1'b0);
    chk("inj_sum_const", 32'(model_sum(8'h00, 8'h00, 0)), 32'h004);
    do_op(WIDTH'($urandom), WIDTH'($urandom), -1, 3, 1'b1);

    // Reset in the middle of RUN at digit index 2.
    a = 8'h12;
    b = 8'h34;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_fc = 0;
    chk("midrun_reset", {20'd0, in_ready, out_valid, fault, sum}, {20'd0, 1'b1, 1'b0, 1'b0, 9'd0});
    chk("midrun_cnt", 32'(fault_count), 32'(exp_fc));
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen |= out_valid;
    end
    chk("no_result", 32'(seen), 32'd0);

    // Random operands, 255 single injected carry flips spread across the run.
    for (int i = 0; i < 10000; i++) begin
      flip = -1;
      if ((i % 39) == 7 && n_inj < 255) begin
        flip = int'($urandom_range(0, N - 1));
        n_inj++;
      end
      stall = ($urandom_range(0, 15) == 0) ? 1 : 0;
      do_op(WIDTH'($urandom), WIDTH'($urandom), flip, stall, 1'b0);
    end
    // One more fault once the counter is full: it must stay saturated.
    do_op(WIDTH'($urandom), WIDTH'($urandom), int'($urandom_range(0, N - 1)), 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
